// File: rtl/wb_writer.sv
// ---------------------------------------------------------------------------
// wb_writer
// Write-back stage that owns the register file's single write port. Each
// cycle it merges the in-order MEM result with out-of-band divider results.
// Divider results wait in a 2-entry FIFO that is drained whenever the
// pipeline leaves the write slot free. Buffered divider results are killed
// when a younger pipeline write targets the same register (WAW). A stall
// request is raised when the divider results have been starved too long.
//
// Parameters
//   STARVE_MAX  blocked cycles with a non-empty FIFO before stall_req (1..15)
// Ports
//   clk         rising-edge clock
//   rst         asynchronous active-high reset
//   M_wb_ena    MEM-stage result valid
//   M_wb_addr   MEM-stage destination register
//   M_wb_data   MEM-stage result
//   D_valid     divider result valid
//   D_ready     block can accept a divider result
//   D_addr      divider destination register
//   D_data      divider result
//   W_w_ena     register-file write enable (registered)
//   W_w_addr    register-file write address (registered)
//   W_w_data    register-file write data (registered)
//   stall_req   ask the hazard unit to bubble the MEM->WB slot
//   fifo_count  FIFO occupancy 0..2 (debug)
// ---------------------------------------------------------------------------
module wb_writer #(
   parameter int unsigned STARVE_MAX = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        M_wb_ena,
   input  logic [4:0]  M_wb_addr,
   input  logic [31:0] M_wb_data,
   input  logic        D_valid,
   output logic        D_ready,
   input  logic [4:0]  D_addr,
   input  logic [31:0] D_data,
   output logic        W_w_ena,
   output logic [4:0]  W_w_addr,
   output logic [31:0] W_w_data,
   output logic        stall_req,
   output logic [1:0]  fifo_count
);

   logic [4:0]  r_entryAddr [2];
   logic [31:0] r_entryData [2];
   logic [1:0]  r_entryLive;
   logic        r_head;
   logic [1:0]  r_count;
   logic [3:0]  r_starveCnt;

   logic        w_pipeWrite;
   logic        w_accept;
   logic        w_push;
   logic        w_pop;
   logic        w_tail;
   logic        w_headLive;
   logic        w_newLive;

   // Register 0 is hardwired, so a MEM result aimed at it is not a write.
   // The FIFO only drains when the pipeline leaves the write slot free.
   // The tail slot is head+count; a push never happens with two entries held.
   // A pushed entry is born dead if the same-cycle pipeline write targets it.
   always_comb begin
      w_pipeWrite = M_wb_ena && (M_wb_addr != 5'd0);
      D_ready     = !rst && (r_count != 2'd2);
      w_accept    = D_valid && D_ready;
      w_push      = w_accept && (D_addr != 5'd0);
      w_pop       = !w_pipeWrite && (r_count != 2'd0);
      w_tail      = r_head ^ r_count[0];
      w_headLive  = r_entryLive[r_head];
      w_newLive   = !(w_pipeWrite && (D_addr == M_wb_addr));
      stall_req   = (r_starveCnt == 4'(STARVE_MAX));
      fifo_count  = r_count;
   end

   // FIFO storage, pointers and WAW kill. The push assignment comes after the
   // kill loop so a freshly written slot takes its own liveness value.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 2; i++) begin
            r_entryAddr[i] <= 5'd0;
            r_entryData[i] <= 32'd0;
         end
         r_entryLive <= 2'b00;
         r_head      <= 1'b0;
         r_count     <= 2'd0;
      end else begin
         for (int i = 0; i < 2; i++) begin
            if (w_pipeWrite && (r_entryAddr[i] == M_wb_addr)) begin
               r_entryLive[i] <= 1'b0;
            end
         end
         if (w_push) begin
            r_entryAddr[w_tail] <= D_addr;
            r_entryData[w_tail] <= D_data;
            r_entryLive[w_tail] <= w_newLive;
         end
         if (w_pop) begin
            r_head <= ~r_head;
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 2'd1;
            2'b01:   r_count <= r_count - 2'd1;
            default: r_count <= r_count;
         endcase
      end
   end

   // Starvation counter: cleared whenever the FIFO drains or is empty, and
   // counts up (saturating) while the pipeline keeps the slot occupied.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_starveCnt <= 4'd0;
      end else if (w_pop || (r_count == 2'd0)) begin
         r_starveCnt <= 4'd0;
      end else if (w_pipeWrite && (r_starveCnt != 4'(STARVE_MAX))) begin
         r_starveCnt <= r_starveCnt + 4'd1;
      end
   end

   // Write-port registers. Pipeline has absolute priority; a dead head is
   // still popped but produces no write. Address/data hold when idle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         W_w_ena  <= 1'b0;
         W_w_addr <= 5'd0;
         W_w_data <= 32'd0;
      end else if (w_pipeWrite) begin
         W_w_ena  <= 1'b1;
         W_w_addr <= M_wb_addr;
         W_w_data <= M_wb_data;
      end else if (w_pop && w_headLive) begin
         W_w_ena  <= 1'b1;
         W_w_addr <= r_entryAddr[r_head];
         W_w_data <= r_entryData[r_head];
      end else begin
         W_w_ena  <= 1'b0;
      end
   end

endmodule

// File: tb/tb_wb_writer.sv
// ---------------------------------------------------------------------------
// tb_wb_writer
// Directed bench for wb_writer: a table of per-cycle stimulus records with
// hand-computed expected outputs, plus hand-written reset sequences.
// ---------------------------------------------------------------------------
module tb_wb_writer;

   logic        clock;
   logic        reset;
   logic        mEna;
   logic [4:0]  mAddr;
   logic [31:0] mData;
   logic        dValid;
   logic        dReady;
   logic [4:0]  dAddr;
   logic [31:0] dData;
   logic        wEna;
   logic [4:0]  wAddr;
   logic [31:0] wData;
   logic        stallReq;
   logic [1:0]  fifoCount;

   int checks;
   int failures;

   typedef struct {
      logic        mEna;
      logic [4:0]  mAddr;
      logic [31:0] mData;
      logic        dValid;
      logic [4:0]  dAddr;
      logic [31:0] dData;
      logic        expEna;
      logic [4:0]  expAddr;
      logic [31:0] expData;
      logic [1:0]  expCount;
      logic        expReady;
      logic        expStall;
   } VecT;

   VecT vecs [18];

   wb_writer #(.STARVE_MAX(4)) dut (
      .clk        (clock),
      .rst        (reset),
      .M_wb_ena   (mEna),
      .M_wb_addr  (mAddr),
      .M_wb_data  (mData),
      .D_valid    (dValid),
      .D_ready    (dReady),
      .D_addr     (dAddr),
      .D_data     (dData),
      .W_w_ena    (wEna),
      .W_w_addr   (wAddr),
      .W_w_data   (wData),
      .stall_req  (stallReq),
      .fifo_count (fifoCount)
   );

   // Free-running 10-unit clock
   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Single comparison with a FAIL line on mismatch
   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   // Drive one cycle's inputs
   task automatic applyStimulus(input logic me, input logic [4:0] ma,
                                input logic [31:0] md, input logic dv,
                                input logic [4:0] da, input logic [31:0] dd);
      mEna   = me;
      mAddr  = ma;
      mData  = md;
      dValid = dv;
      dAddr  = da;
      dData  = dd;
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // Test sequence
   initial begin
      checks   = 0;
      failures = 0;

      // 0: pipeline pass-through
      vecs[0]  = '{1'b1, 5'd5,  32'hDEADBEEF, 1'b0, 5'd0,  32'h0,      1'b1, 5'd5,  32'hDEADBEEF, 2'd0, 1'b1, 1'b0};
      // 1: $0 pipeline write suppressed, addr/data hold
      vecs[1]  = '{1'b1, 5'd0,  32'h1,        1'b0, 5'd0,  32'h0,      1'b0, 5'd5,  32'hDEADBEEF, 2'd0, 1'b1, 1'b0};
      // 2: divider result to $0 is discarded
      vecs[2]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd0,  32'h55,     1'b0, 5'd5,  32'hDEADBEEF, 2'd0, 1'b1, 1'b0};
      // 3..8: pipeline every cycle while divider pushes 3 results
      vecs[3]  = '{1'b1, 5'd1,  32'h11,       1'b1, 5'd10, 32'hA0,     1'b1, 5'd1,  32'h11,       2'd1, 1'b1, 1'b0};
      vecs[4]  = '{1'b1, 5'd2,  32'h22,       1'b1, 5'd11, 32'hB0,     1'b1, 5'd2,  32'h22,       2'd2, 1'b0, 1'b0};
      vecs[5]  = '{1'b1, 5'd3,  32'h33,       1'b1, 5'd12, 32'hC0,     1'b1, 5'd3,  32'h33,       2'd2, 1'b0, 1'b0};
      vecs[6]  = '{1'b1, 5'd4,  32'h44,       1'b1, 5'd12, 32'hC0,     1'b1, 5'd4,  32'h44,       2'd2, 1'b0, 1'b0};
      vecs[7]  = '{1'b1, 5'd6,  32'h66,       1'b1, 5'd12, 32'hC0,     1'b1, 5'd6,  32'h66,       2'd2, 1'b0, 1'b1};
      vecs[8]  = '{1'b1, 5'd8,  32'h88,       1'b1, 5'd12, 32'hC0,     1'b1, 5'd8,  32'h88,       2'd2, 1'b0, 1'b1};
      // 9: M idle, head (r10) drains; D_valid not accepted since full
      vecs[9]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd12, 32'hC0,     1'b1, 5'd10, 32'hA0,       2'd1, 1'b1, 1'b0};
      // 10: simultaneous push (r12) and pop (r11)
      vecs[10] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd12, 32'hC0,     1'b1, 5'd11, 32'hB0,       2'd1, 1'b1, 1'b0};
      // 11: r12 drains
      vecs[11] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,      1'b1, 5'd12, 32'hC0,       2'd0, 1'b1, 1'b0};
      // 12: idle
      vecs[12] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,      1'b0, 5'd12, 32'hC0,       2'd0, 1'b1, 1'b0};
      // 13..15: WAW kill of a queued r7 result
      vecs[13] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd7,  32'hAAAA,   1'b0, 5'd12, 32'hC0,       2'd1, 1'b1, 1'b0};
      vecs[14] = '{1'b1, 5'd7,  32'hBBBB,     1'b0, 5'd0,  32'h0,      1'b1, 5'd7,  32'hBBBB,     2'd1, 1'b1, 1'b0};
      vecs[15] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,      1'b0, 5'd7,  32'hBBBB,     2'd0, 1'b1, 1'b0};
      // 16..17: same-cycle kill of an entry being enqueued
      vecs[16] = '{1'b1, 5'd9,  32'h99,       1'b1, 5'd9,  32'h9999,   1'b1, 5'd9,  32'h99,       2'd1, 1'b1, 1'b0};
      vecs[17] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,      1'b0, 5'd9,  32'h99,       2'd0, 1'b1, 1'b0};

      // Power-on reset
      reset = 1'b1;
      applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
      #2;
      checkOutput("por_w_ena",  32'(wEna),      32'd0);
      checkOutput("por_ready",  32'(dReady),    32'd0);
      checkOutput("por_count",  32'(fifoCount), 32'd0);
      checkOutput("por_stall",  32'(stallReq),  32'd0);
      tick();
      reset = 1'b0;
      #1;
      checkOutput("por_release_ready", 32'(dReady), 32'd1);

      // Table-driven vectors
      for (int i = 0; i < 18; i++) begin
         applyStimulus(vecs[i].mEna, vecs[i].mAddr, vecs[i].mData,
                       vecs[i].dValid, vecs[i].dAddr, vecs[i].dData);
         tick();
         checkOutput($sformatf("v%0d_w_ena", i),  32'(wEna),      32'(vecs[i].expEna));
         checkOutput($sformatf("v%0d_w_addr", i), 32'(wAddr),     32'(vecs[i].expAddr));
         checkOutput($sformatf("v%0d_w_data", i), wData,          vecs[i].expData);
         checkOutput($sformatf("v%0d_count", i),  32'(fifoCount), 32'(vecs[i].expCount));
         checkOutput($sformatf("v%0d_ready", i),  32'(dReady),    32'(vecs[i].expReady));
         checkOutput($sformatf("v%0d_stall", i),  32'(stallReq),  32'(vecs[i].expStall));
      end

      // Mid-cycle asynchronous reset with two entries queued
      applyStimulus(1'b1, 5'd1, 32'h101, 1'b1, 5'd3, 32'h303);
      tick();
      applyStimulus(1'b1, 5'd2, 32'h202, 1'b1, 5'd4, 32'h404);
      tick();
      checkOutput("pre_rst_count", 32'(fifoCount), 32'd2);
      applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
      #3;
      reset = 1'b1;
      #1;
      checkOutput("arst_w_ena",  32'(wEna),      32'd0);
      checkOutput("arst_w_addr", 32'(wAddr),     32'd0);
      checkOutput("arst_w_data", wData,          32'd0);
      checkOutput("arst_count",  32'(fifoCount), 32'd0);
      checkOutput("arst_ready",  32'(dReady),    32'd0);
      checkOutput("arst_stall",  32'(stallReq),  32'd0);
      #2;
      reset = 1'b0;
      #1;
      checkOutput("arst_release_ready", 32'(dReady), 32'd1);
      // Queued results must be gone: idle cycle produces no write
      tick();
      checkOutput("arst_drain_w_ena", 32'(wEna),      32'd0);
      checkOutput("arst_drain_count", 32'(fifoCount), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/wb_writer.md
# wb_writer

Write-back stage that owns the register file's single write port (W_w_ena / W_w_addr / W_w_data). Each cycle it merges the in-order pipeline result from MEM with out-of-band results from the multi-cycle divider. Divider results are buffered in a 2-entry FIFO and handed off over a valid/ready handshake. The block also kills stale divider writes (WAW) and requests a pipeline stall when divider results starve.

## Interface
- STARVE_MAX, 4: consecutive blocked cycles with a non-empty FIFO before stall_req asserts; valid range 1..15.
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- M_wb_ena  in  1  MEM-stage result valid this cycle
- M_wb_addr  in  5  MEM-stage destination register
- M_wb_data  in  32  MEM-stage result
- D_valid  in  1  divider result valid
- D_ready  out  1  block can accept a divider result
- D_addr  in  5  divider destination register
- D_data  in  32  divider result
- W_w_ena  out  1  register-file write enable (registered)
- W_w_addr  out  5  register-file write address (registered)
- W_w_data  out  32  register-file write data (registered)
- stall_req  out  1  request to the hazard unit to bubble the MEM→WB slot
- fifo_count  out  2  FIFO occupancy, 0..2 (debug)

## Operation
- A pipeline write is a cycle with M_wb_ena=1 and M_wb_addr!=0. An address of 0 is never written by any path.
- Divider accept: D_valid && D_ready.
  - D_ready = !rst && fifo_count<2. It does not depend on a same-cycle pop.
  - An accepted result with D_addr=0 is consumed and discarded, not enqueued.
- FIFO entry: {addr[4:0], data[31:0], live}. Entries are written in order and popped from the head.
- Per-cycle selection, evaluated at the posedge:
  - Pipeline write present: the output registers load {1, M_wb_addr, M_wb_data}. No pop. Pipeline priority is absolute.
  - No pipeline write, FIFO non-empty, head live: pop the head. The output registers load {1, head.addr, head.data}.
  - No pipeline write, FIFO non-empty, head dead: pop the head. W_w_ena loads 0.
  - Otherwise W_w_ena loads 0. W_w_addr and W_w_data hold their previous values.
- WAW kill: a pipeline write to register R clears live on every FIFO entry with addr==R. This includes an entry enqueued in the same cycle. The pipeline write is always the younger producer.
- Push and pop in the same cycle are allowed. Occupancy is unchanged and the pushed entry lands behind the new head.
- Starvation counter starve_cnt (4 bits):
  - Clears to 0 on any pop or when the FIFO is empty.
  - Otherwise increments when a pipeline write blocks a non-empty FIFO.
  - Saturates at STARVE_MAX.
- stall_req = (starve_cnt == STARVE_MAX), combinational from the register.
  - The hazard unit then presents M_wb_ena=0 for that cycle.
  - If M_wb_ena is still 1, the pipeline still wins and stall_req stays high.

## Timing
- Reset (asynchronous, immediate):
  - FIFO emptied, all live bits cleared, starve_cnt=0.
  - W_w_ena=0, W_w_addr=0, W_w_data=0.
  - stall_req=0, fifo_count=0, D_ready=0.
- Reset asserted mid-operation discards buffered results and any in-flight accept.
- Pipeline path latency: 1 cycle. MEM inputs at edge N appear on W_w_* after edge N, and the register file commits at edge N+1.
- Divider path latency: a minimum of 2 cycles. Accept at edge N, pop at edge N+1 if the pipeline slot is free, W_w_* valid after edge N+1.
- D_ready deasserts in the cycle after an accept that fills the FIFO. It reasserts in the cycle after a pop.
- stall_req rises the cycle after the STARVE_MAX-th blocked edge. It falls the cycle after the pop.

## Test plan
- Reset state: assert rst asynchronously mid-cycle with 2 entries queued. Required: W_w_ena=0, W_w_addr=0, W_w_data=0, fifo_count=0, D_ready=0 immediately; after release D_ready=1.
- Pipeline pass-through: M_wb_ena=1, addr=5, data=0xDEADBEEF. Required: W_w_ena=1, W_w_addr=5, W_w_data=0xDEADBEEF one cycle later.
- $0 suppression:
  - M addr=0, data=0x1: required W_w_ena=0.
  - D accept with addr=0: required fifo_count stays 0 and no write.
- Divider buffering and backpressure:
  - Pipeline writes every cycle while D pushes 3 results. Required: D_ready=0 after 2 accepts.
  - stall_req rises after 4 blocked cycles.
  - With M idle, both entries drain in order on consecutive cycles.
- WAW kill: queue D {addr=7, 0xAAAA}, then pipeline writes r7=0xBBBB. Required: r7 ends at 0xBBBB. The dead entry pops with W_w_ena=0.
- Simultaneous push/pop: FIFO holds 1 entry, M idle, D_valid=1. Required: the head is written, the new entry is queued, and fifo_count stays 1.
